// File: rtl/video_ctrl_pkg.sv
// Shared types and default widths for the test-video streaming controllers.
package video_ctrl_pkg;

   typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} vss_state_t;

   localparam int FCNT_W_DEF    = 16;
   localparam int STALL_W_DEF   = 8;
   localparam int STALL_MAX_DEF = 16;

endpackage

// File: rtl/stream_stall_monitor.sv
// Counts consecutive tvalid&&!tready cycles; flags the cycle in which the run of
// stalls reaches STALL_MAX so the scheduler can abort the non-stallable video path.
module stream_stall_monitor
   import video_ctrl_pkg::*;
#(
   parameter int STALL_W   = STALL_W_DEF,
   parameter int STALL_MAX = STALL_MAX_DEF
) (
   input  logic clock,
   input  logic clear,
   input  logic enable,
   input  logic tvalid,
   input  logic tready,
   output logic err_pulse
);

   localparam logic [STALL_W-1:0] LAST = STALL_W'(STALL_MAX - 1);

   logic [STALL_W-1:0] cnt;
   logic               stall;

   assign stall = tvalid & ~tready;
   // Fires on the STALL_MAX-th consecutive stall cycle, before the counter itself gets there.
   assign err_pulse = enable & stall & (cnt == LAST);

   always_ff @(posedge clock) begin
      if (clear) begin
         cnt <= '0;
      end else if (enable && stall) begin
         cnt <= cnt + 1'b1;
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/video_stream_scheduler.sv
// Frame-aligned run controller: gates the native-to-AXIS bridge so streams start and
// end on whole frames, counts delivered frames and aborts on excessive back-pressure.
module video_stream_scheduler
   import video_ctrl_pkg::*;
#(
   parameter int FCNT_W    = FCNT_W_DEF,
   parameter int STALL_W   = STALL_W_DEF,
   parameter int STALL_MAX = STALL_MAX_DEF
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [FCNT_W-1:0] frame_num,
   input  logic              vsync,
   input  logic              axis_tvalid,
   input  logic              axis_tready,
   output logic              stream_enable,
   output logic              busy,
   output logic              done,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              stall_err
);

   vss_state_t        state;
   logic [FCNT_W-1:0] target;
   logic [FCNT_W-1:0] cnt_inc;
   logic              vsync_q;
   logic              fb;
   logic              in_run;
   logic              stall_hit;

   assign in_run  = (state == RUN) || (state == DRAIN);
   assign cnt_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;

   stream_stall_monitor #(
      .STALL_W   (STALL_W),
      .STALL_MAX (STALL_MAX)
   ) u_stall_mon (
      .clock     (clock),
      .clear     (rst | ~in_run),
      .enable    (in_run),
      .tvalid    (axis_tvalid),
      .tready    (axis_tready),
      .err_pulse (stall_hit)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         state         <= IDLE;
         stream_enable <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         frame_cnt     <= '0;
         stall_err     <= 1'b0;
         target        <= '0;
         vsync_q       <= 1'b0;
         fb            <= 1'b0;
      end else begin
         // Boundary is registered: the FSM reacts two cycles after vsync rises at the pin.
         vsync_q <= vsync;
         fb      <= vsync & ~vsync_q;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state     <= ARM;
                  busy      <= 1'b1;
                  target    <= frame_num;
                  frame_cnt <= '0;
                  stall_err <= 1'b0;
               end
            end
            ARM: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (fb) begin
                  state         <= RUN;
                  stream_enable <= 1'b1;
               end
            end
            RUN: begin
               if (stall_hit) begin
                  state         <= IDLE;
                  stream_enable <= 1'b0;
                  busy          <= 1'b0;
                  stall_err     <= 1'b1;
               end else if (fb) begin
                  frame_cnt <= cnt_inc;
                  if (stop || ((target != '0) && (cnt_inc == target))) begin
                     state         <= DONE;
                     stream_enable <= 1'b0;
                     busy          <= 1'b0;
                     done          <= 1'b1;
                  end
               end else if (stop) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (stall_hit) begin
                  state         <= IDLE;
                  stream_enable <= 1'b0;
                  busy          <= 1'b0;
                  stall_err     <= 1'b1;
               end else if (fb) begin
                  frame_cnt     <= cnt_inc;
                  state         <= DONE;
                  stream_enable <= 1'b0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state         <= IDLE;
               stream_enable <= 1'b0;
               busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_stream_scheduler.sv
// Self-checking bench for video_stream_scheduler: frame-count scoreboard plus per-scenario checks.
module tb_video_stream_scheduler;

   logic        clock;
   logic        rst;
   logic        start;
   logic        stop;
   logic [15:0] frame_num;
   logic        vsync;
   logic        axis_tvalid;
   logic        axis_tready;
   logic        stream_enable;
   logic        busy;
   logic        done;
   logic [15:0] frame_cnt;
   logic        stall_err;

   typedef struct packed {
      logic [15:0] cnt;
      logic        dn;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   video_stream_scheduler dut (
      .clock         (clock),
      .rst           (rst),
      .start         (start),
      .stop          (stop),
      .frame_num     (frame_num),
      .vsync         (vsync),
      .axis_tvalid   (axis_tvalid),
      .axis_tready   (axis_tready),
      .stream_enable (stream_enable),
      .busy          (busy),
      .done          (done),
      .frame_cnt     (frame_cnt),
      .stall_err     (stall_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Scoreboard: every new nonzero frame count or done pulse must match the next queued expectation.
   initial begin
      logic [15:0] prev_cnt;
      exp_t        e;
      prev_cnt = '0;
      forever begin
         @(negedge clock);
         if (((frame_cnt != prev_cnt) && (frame_cnt != 16'd0)) || (done === 1'b1)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected: got cnt=%0d done=%b, required no output event", frame_cnt, done);
            end else begin
               e = exp_q.pop_front();
               if ((frame_cnt !== e.cnt) || (done !== e.dn))
                  $display("FAIL sb_event: got cnt=%0d done=%b, required cnt=%0d done=%b",
                           frame_cnt, done, e.cnt, e.dn);
               else
                  n_pass++;
            end
         end
         prev_cnt = frame_cnt;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_start(input logic [15:0] n);
      frame_num = n;
      start     = 1'b1;
      tick(1);
      start     = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
   endtask

   // Returns when the registered boundary has been acted on by the FSM.
   task automatic fb_edge();
      vsync = 1'b1;
      tick(2);
   endtask

   task automatic frame_rest(input int n);
      vsync = 1'b0;
      tick(n);
   endtask

   task automatic push_exp(input logic [15:0] c, input logic d);
      exp_t e;
      e.cnt = c;
      e.dn  = d;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      n_checks++;
      if ({stream_enable, busy, done, stall_err} !== 4'b0000)
         $display("FAIL reset_flags: got en/busy/done/err=%b, required 0000", {stream_enable, busy, done, stall_err});
      else n_pass++;
      n_checks++;
      if (frame_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d, required 0", frame_cnt);
      else n_pass++;
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_nframes();
      do_start(16'd3);
      n_checks++;
      if ({busy, stream_enable} !== 2'b10)
         $display("FAIL nf_arm: got busy/en=%b, required 10", {busy, stream_enable});
      else n_pass++;
      frame_rest(5);
      fb_edge();
      n_checks++;
      if (stream_enable !== 1'b1) $display("FAIL nf_enable_rise: got %b, required 1", stream_enable);
      else n_pass++;
      frame_rest(15);
      for (int k = 1; k <= 3; k++) begin
         push_exp(16'(k), (k == 3));
         fb_edge();
         n_checks++;
         if (stream_enable !== (k < 3)) $display("FAIL nf_enable_f%0d: got %b, required %b", k, stream_enable, (k < 3));
         else n_pass++;
         if (k < 3) frame_rest(15);
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL nf_busy_done: got %b, required 0", busy);
      else n_pass++;
      frame_rest(1);
      n_checks++;
      if (done !== 1'b0) $display("FAIL nf_done_width: got %b, required 0", done);
      else n_pass++;
      frame_rest(10);
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL nf_sb_drain: got %0d pending, required 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_continuous_stop();
      do_start(16'd0);
      frame_rest(5);
      fb_edge();
      frame_rest(15);
      for (int k = 1; k <= 5; k++) begin
         push_exp(16'(k), 1'b0);
         fb_edge();
         frame_rest(3);
         // A start while busy must not relatch frame_num = 2.
         if (k == 1) do_start(16'd2);
         frame_rest(12);
      end
      frame_rest(4);
      pulse_stop();
      n_checks++;
      if ({busy, stream_enable} !== 2'b11)
         $display("FAIL cont_drain: got busy/en=%b, required 11", {busy, stream_enable});
      else n_pass++;
      frame_rest(5);
      pulse_stop();
      push_exp(16'd6, 1'b1);
      fb_edge();
      n_checks++;
      if ({done, stream_enable, frame_cnt} !== {1'b1, 1'b0, 16'd6})
         $display("FAIL cont_done: got done=%b en=%b cnt=%0d, required 1 0 6", done, stream_enable, frame_cnt);
      else n_pass++;
      frame_rest(10);
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL cont_sb_drain: got %0d pending, required 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_stop_before_fb();
      do_start(16'd2);
      frame_rest(3);
      pulse_stop();
      n_checks++;
      if ({busy, stream_enable} !== 2'b00)
         $display("FAIL early_stop_idle: got busy/en=%b, required 00", {busy, stream_enable});
      else n_pass++;
      fb_edge();
      frame_rest(3);
      n_checks++;
      if ({stream_enable, done, frame_cnt} !== {1'b0, 1'b0, 16'd0})
         $display("FAIL early_stop_quiet: got en=%b done=%b cnt=%0d, required 0 0 0", stream_enable, done, frame_cnt);
      else n_pass++;
      frame_rest(10);
   endtask

   task automatic test_stall();
      do_start(16'd0);
      frame_rest(3);
      fb_edge();
      frame_rest(3);
      axis_tready = 1'b0;
      tick(15);
      axis_tready = 1'b1;
      tick(3);
      n_checks++;
      if ({stall_err, stream_enable} !== 2'b01)
         $display("FAIL stall_15: got err/en=%b, required 01", {stall_err, stream_enable});
      else n_pass++;
      axis_tready = 1'b0;
      tick(16);
      n_checks++;
      if ({stall_err, stream_enable, busy, done} !== 4'b1000)
         $display("FAIL stall_16: got err/en/busy/done=%b, required 1000", {stall_err, stream_enable, busy, done});
      else n_pass++;
      axis_tready = 1'b1;
      tick(5);
      n_checks++;
      if (stall_err !== 1'b1) $display("FAIL stall_sticky: got %b, required 1", stall_err);
      else n_pass++;
      do_start(16'd1);
      n_checks++;
      if ({stall_err, busy} !== 2'b01)
         $display("FAIL stall_clear: got err/busy=%b, required 01", {stall_err, busy});
      else n_pass++;
      frame_rest(3);
      fb_edge();
      frame_rest(10);
      push_exp(16'd1, 1'b1);
      fb_edge();
      frame_rest(10);
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL stall_sb_drain: got %0d pending, required 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_stop_with_fb();
      do_start(16'd0);
      frame_rest(3);
      fb_edge();
      frame_rest(10);
      for (int k = 1; k <= 2; k++) begin
         push_exp(16'(k), 1'b0);
         fb_edge();
         frame_rest(10);
      end
      push_exp(16'd3, 1'b1);
      vsync = 1'b1;
      tick(1);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      n_checks++;
      if ({done, stream_enable, frame_cnt} !== {1'b1, 1'b0, 16'd3})
         $display("FAIL stopfb_done: got done=%b en=%b cnt=%0d, required 1 0 3", done, stream_enable, frame_cnt);
      else n_pass++;
      frame_rest(5);
      start = 1'b1;
      stop  = 1'b1;
      frame_num = 16'd4;
      tick(1);
      start = 1'b0;
      stop  = 1'b0;
      n_checks++;
      if ({busy, frame_cnt} !== {1'b0, 16'd3})
         $display("FAIL start_stop_idle: got busy=%b cnt=%0d, required 0 3", busy, frame_cnt);
      else n_pass++;
      frame_rest(5);
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL stopfb_sb_drain: got %0d pending, required 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_rst_midrun();
      do_start(16'd0);
      frame_rest(3);
      fb_edge();
      frame_rest(10);
      for (int k = 1; k <= 2; k++) begin
         push_exp(16'(k), 1'b0);
         fb_edge();
         frame_rest(10);
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      n_checks++;
      if ({stream_enable, busy, done, stall_err, frame_cnt} !== 20'd0)
         $display("FAIL rst_mid: got en=%b busy=%b done=%b err=%b cnt=%0d, required all 0",
                  stream_enable, busy, done, stall_err, frame_cnt);
      else n_pass++;
      frame_rest(3);
      do_start(16'd1);
      frame_rest(3);
      fb_edge();
      n_checks++;
      if (stream_enable !== 1'b1) $display("FAIL rst_rearm_en: got %b, required 1", stream_enable);
      else n_pass++;
      frame_rest(10);
      push_exp(16'd1, 1'b1);
      fb_edge();
      frame_rest(10);
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL rst_sb_drain: got %0d pending, required 0", exp_q.size());
      else n_pass++;
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      stop        = 1'b0;
      frame_num   = '0;
      vsync       = 1'b0;
      axis_tvalid = 1'b1;
      axis_tready = 1'b1;
      test_reset();
      test_nframes();
      test_continuous_stop();
      test_stop_before_fb();
      test_stall();
      test_stop_with_fb();
      test_rst_midrun();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
